// File: rtl/pixel_stream_avg_if.sv
// Pixel-stream averager bus: the framed input stream (valid/ready/last)
// and the averaged-result channel (valid/ready plus count and overflow).
//   slave  modport : the averaging engine
//   master modport : the pixel source / result consumer
// Pixel packing: channel 0 occupies the MSBs [PIX_W-1 -: CH_W].
interface pixel_stream_avg_if #(
    parameter int NUM_CH = 3,
    parameter int CH_W   = 8,
    parameter int CNT_W  = 20
);
    localparam int PIX_W = NUM_CH * CH_W;

    logic             pixel_valid;
    logic             pixel_ready;
    logic [PIX_W-1:0] pixel_input;
    logic             pixel_last;
    logic [PIX_W-1:0] avg_pixel;
    logic             avg_valid;
    logic             avg_ready;
    logic [CNT_W-1:0] pixel_count;
    logic             overflow;

    modport slave (
        input  pixel_valid, pixel_input, pixel_last, avg_ready,
        output pixel_ready, avg_pixel, avg_valid, pixel_count, overflow
    );

    modport master (
        output pixel_valid, pixel_input, pixel_last, avg_ready,
        input  pixel_ready, avg_pixel, avg_valid, pixel_count, overflow
    );
endinterface

// File: rtl/pixel_stream_avg.sv
// Streaming per-channel mean engine.
// Accumulates a framed pixel stream into per-channel sums and a pixel count,
// divides each sum by the count with a restoring divider (one quotient bit
// per cycle, ACC_W cycles), and presents the averaged pixel with backpressure.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset (aborts any frame in progress)
//   bus   : pixel_stream_avg_if.slave (pixel_* input stream, avg_* result,
//           pixel_count, overflow)
// Optional build macro PIXEL_AVG_ROUND_EN: adds floor(count/2) to each
// dividend for round-half-up; undefined gives a floor average.
module pixel_stream_avg #(
    parameter int NUM_CH = 3,
    parameter int CH_W   = 8,
    parameter int CNT_W  = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    pixel_stream_avg_if.slave    bus
);
    localparam int PIX_W     = NUM_CH * CH_W;
    localparam int ACC_W     = CH_W + CNT_W;
    localparam int DIV_CNT_W = $clog2(ACC_W + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

    state_t               state;
    logic [ACC_W-1:0]     acc [NUM_CH];   // running sum, then dividend/quotient shift register
    logic [CNT_W-1:0]     rem [NUM_CH];   // partial remainder, always < count
    logic [CNT_W-1:0]     count;
    logic                 ovf_int;
    logic [DIV_CNT_W-1:0] div_cnt;

    logic                 accept;
    logic                 max_hit;
    logic                 to_divide;
    logic [CNT_W-1:0]     count_next;
    logic [ACC_W-1:0]     sum_next  [NUM_CH];
    logic [ACC_W-1:0]     dividend  [NUM_CH];
    logic [ACC_W-1:0]     acc_step  [NUM_CH];
    logic [CNT_W-1:0]     rem_step  [NUM_CH];
    logic [CNT_W:0]       trial     [NUM_CH];
    logic [PIX_W-1:0]     quotient;

    assign accept    = bus.pixel_valid && bus.pixel_ready;
    assign max_hit   = (state == ACCUM) && (count_next == {CNT_W{1'b1}});
    assign to_divide = bus.pixel_last || max_hit;

    // NOTE: every combinational output gets a default at the top of the block
    // so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        count_next = (state == IDLE) ? CNT_W'(1) : count + 1'b1;
        quotient   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sum_next[c] = ACC_W'(bus.pixel_input[PIX_W-1-c*CH_W -: CH_W]);
            if (state != IDLE) begin
                sum_next[c] = sum_next[c] + acc[c];
            end
`ifdef PIXEL_AVG_ROUND_EN
            dividend[c] = sum_next[c] + ACC_W'(count_next >> 1);
`else
            dividend[c] = sum_next[c];
`endif
            // Shift the next dividend bit into the remainder; subtract the
            // divisor when it fits and shift the quotient bit in at the LSB.
            trial[c] = {rem[c], acc[c][ACC_W-1]};
            if (trial[c] >= {1'b0, count}) begin
                rem_step[c] = CNT_W'(trial[c] - {1'b0, count});
                acc_step[c] = {acc[c][ACC_W-2:0], 1'b1};
            end else begin
                rem_step[c] = trial[c][CNT_W-1:0];
                acc_step[c] = {acc[c][ACC_W-2:0], 1'b0};
            end
            // Sum never exceeds count*(2^CH_W-1), so the quotient fits CH_W bits.
            quotient[PIX_W-1-c*CH_W -: CH_W] = acc[c][CH_W-1:0];
        end
    end

    // NOTE: all state is assigned with non-blocking <= so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bus.pixel_ready <= 1'b1;
            bus.avg_valid   <= 1'b0;
            bus.avg_pixel   <= '0;
            bus.pixel_count <= '0;
            bus.overflow    <= 1'b0;
            count           <= '0;
            ovf_int         <= 1'b0;
            div_cnt         <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
                rem[c] <= '0;
            end
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        count   <= count_next;
                        ovf_int <= max_hit;
                        div_cnt <= '0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            acc[c] <= to_divide ? dividend[c] : sum_next[c];
                            rem[c] <= '0;
                        end
                        if (to_divide) begin
                            state           <= DIVIDE;
                            bus.pixel_ready <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DIVIDE: begin
                    if (div_cnt == DIV_CNT_W'(ACC_W)) begin
                        state           <= DONE;
                        bus.avg_valid   <= 1'b1;
                        bus.avg_pixel   <= quotient;
                        bus.pixel_count <= count;
                        bus.overflow    <= ovf_int;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                        for (int c = 0; c < NUM_CH; c++) begin
                            acc[c] <= acc_step[c];
                            rem[c] <= rem_step[c];
                        end
                    end
                end
                DONE: begin
                    // Result handshake only; a waiting beat is taken in IDLE.
                    if (bus.avg_ready) begin
                        state           <= IDLE;
                        bus.avg_valid   <= 1'b0;
                        bus.pixel_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_stream_avg.sv
// Self-checking bench for pixel_stream_avg: a table of known frames, hand
// sequences for backpressure, reset abort and force-close (CNT_W=3 instance),
// and random frames checked against an arithmetic mean model.
module tb_pixel_stream_avg;
    localparam int LAT       = 29;   // default ACC_W + 1
    localparam int LAT_SMALL = 12;   // CNT_W=3: ACC_W=11

`ifdef PIXEL_AVG_ROUND_EN
    localparam logic [23:0] EXP_ONE = 24'h010101;
    localparam logic [23:0] EXP_MIX = 24'h005501;
`else
    localparam logic [23:0] EXP_ONE = 24'h000000;
    localparam logic [23:0] EXP_MIX = 24'h005500;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pixel_stream_avg_if #(.NUM_CH(3), .CH_W(8), .CNT_W(20)) bus ();
    pixel_stream_avg_if #(.NUM_CH(3), .CH_W(8), .CNT_W(3))  sbus ();

    pixel_stream_avg #(.NUM_CH(3), .CH_W(8), .CNT_W(20)) u_dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    pixel_stream_avg #(.NUM_CH(3), .CH_W(8), .CNT_W(3)) u_small (
        .clk(clk), .reset(reset), .bus(sbus)
    );

    typedef struct {
        int          n;
        logic [95:0] pix;       // beat b at [95-24*b -: 24]
        logic [23:0] exp_avg;
    } vec_t;

    vec_t        table_v [5];
    logic [23:0] pix_buf [64];
    int          vectors = 0;
    int          miscompares = 0;
    int          accept_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Mean of the first n beats of pix_buf, straight from the definition.
    function automatic logic [23:0] model_avg(input int n);
        logic [23:0] r;
        longint s;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            s = 0;
            for (int i = 0; i < n; i++) s += longint'(pix_buf[i][23-8*c -: 8]);
`ifdef PIXEL_AVG_ROUND_EN
            s += n / 2;
`endif
            s = s / n;
            r[23-8*c -: 8] = s[7:0];
        end
        return r;
    endfunction

    task automatic send_beat(input logic [23:0] p, input logic last);
        int w;
        w = 0;
        bus.pixel_valid = 1'b1;
        bus.pixel_input = p;
        bus.pixel_last  = last;
        while (!bus.pixel_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 200) fail_timeout("send_beat");
        @(posedge clk); #1;
        accept_cyc = cyc;
        bus.pixel_valid = 1'b0;
        bus.pixel_last  = 1'b0;
    endtask

    task automatic send_small(input logic [23:0] p, input logic last);
        int w;
        w = 0;
        sbus.pixel_valid = 1'b1;
        sbus.pixel_input = p;
        sbus.pixel_last  = last;
        while (!sbus.pixel_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 200) fail_timeout("send_small");
        @(posedge clk); #1;
        accept_cyc = cyc;
        sbus.pixel_valid = 1'b0;
        sbus.pixel_last  = 1'b0;
    endtask

    // Wait for the result, check it and its latency, hold avg_ready low for
    // `hold` cycles checking stability, then complete the handshake.
    task automatic wait_result(input string name, input logic [23:0] exp_avg,
                               input int exp_cnt, input logic exp_ovf, input int hold);
        int w;
        w = 0;
        while (!bus.avg_valid && w < 200) begin
            @(posedge clk); #1; w++;
        end
        if (!bus.avg_valid) begin
            fail_timeout({name, "_valid"});
            return;
        end
        check({name, "_latency"}, 64'(cyc - accept_cyc), 64'(LAT));
        check({name, "_avg"},     64'(bus.avg_pixel),    64'(exp_avg));
        check({name, "_count"},   64'(bus.pixel_count),  64'(exp_cnt));
        check({name, "_ovf"},     64'(bus.overflow),     64'(exp_ovf));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, "_hold_valid"}, 64'(bus.avg_valid),   64'(1));
            check({name, "_hold_avg"},   64'(bus.avg_pixel),   64'(exp_avg));
            check({name, "_hold_ready"}, 64'(bus.pixel_ready), 64'(0));
        end
        bus.avg_ready = 1'b1;
        @(posedge clk); #1;
        bus.avg_ready = 1'b0;
        check({name, "_post_valid"}, 64'(bus.avg_valid),   64'(0));
        check({name, "_post_ready"}, 64'(bus.pixel_ready), 64'(1));
        check({name, "_post_avg"},   64'(bus.avg_pixel),   64'(exp_avg));
    endtask

    initial begin
        int n;
        int w;

        table_v[0] = '{4, 96'h102030_304050_506070_708090, 24'h405060};
        table_v[1] = '{2, {48'h000000_010101, 48'h0},      EXP_ONE};
        table_v[2] = '{1, {24'hFFFFFF, 72'h0},             24'hFFFFFF};
        table_v[3] = '{2, {48'h202020_404040, 48'h0},      24'h303030};
        table_v[4] = '{3, {72'h00FF01_010000_000001, 24'h0}, EXP_MIX};

        bus.pixel_valid  = 1'b0;  bus.pixel_input  = '0;  bus.pixel_last  = 1'b0;
        bus.avg_ready    = 1'b0;
        sbus.pixel_valid = 1'b0;  sbus.pixel_input = '0;  sbus.pixel_last = 1'b0;
        sbus.avg_ready   = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.pixel_ready), 64'(1));
        check("rst_valid", 64'(bus.avg_valid),   64'(0));
        check("rst_avg",   64'(bus.avg_pixel),   64'(0));
        check("rst_count", 64'(bus.pixel_count), 64'(0));
        check("rst_ovf",   64'(bus.overflow),    64'(0));
        reset = 1'b0;

        // Table of known frames.
        for (int i = 0; i < 5; i++) begin
            for (int b = 0; b < table_v[i].n; b++) begin
                send_beat(table_v[i].pix[95-24*b -: 24], b == table_v[i].n - 1);
                check($sformatf("tbl%0d_ready_b%0d", i, b), 64'(bus.pixel_ready),
                      64'(b != table_v[i].n - 1));
            end
            wait_result($sformatf("tbl%0d", i), table_v[i].exp_avg, table_v[i].n, 1'b0, i);
        end

        // Backpressure in DONE with a beat waiting; it must be taken only in IDLE.
        send_beat(24'h101010, 1'b1);
        bus.pixel_valid = 1'b1;
        bus.pixel_input = 24'h111111;
        bus.pixel_last  = 1'b0;
        wait_result("bp", 24'h101010, 1, 1'b0, 10);
        @(posedge clk); #1;
        bus.pixel_valid = 1'b0;
        send_beat(24'h333333, 1'b1);
        wait_result("bp_next", 24'h222222, 2, 1'b0, 0);

        // Reset in ACCUM aborts the frame.
        for (int b = 0; b < 3; b++) send_beat(24'hAAAAAA, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_ready", 64'(bus.pixel_ready), 64'(1));
        check("abort_valid", 64'(bus.avg_valid),   64'(0));
        check("abort_avg",   64'(bus.avg_pixel),   64'(0));
        check("abort_count", 64'(bus.pixel_count), 64'(0));
        check("abort_ovf",   64'(bus.overflow),    64'(0));
        send_beat(24'h202020, 1'b0);
        send_beat(24'h404040, 1'b1);
        wait_result("after_abort", 24'h303030, 2, 1'b0, 0);

        // Random frames against the mean model.
        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(1, 16);
            for (int b = 0; b < n; b++) pix_buf[b] = 24'($urandom);
            for (int b = 0; b < n; b++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send_beat(pix_buf[b], b == n - 1);
            end
            wait_result($sformatf("rnd%0d", f), model_avg(n), n, 1'b0, $urandom_range(0, 3));
        end

        // Force close on the CNT_W=3 instance: 7th accept closes the frame.
        for (int b = 0; b < 7; b++) send_small(24'h080808, 1'b0);
        check("fc_ready", 64'(sbus.pixel_ready), 64'(0));
        sbus.pixel_valid = 1'b1;
        sbus.pixel_input = 24'h080808;
        sbus.pixel_last  = 1'b1;
        w = 0;
        while (!sbus.avg_valid && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (!sbus.avg_valid) fail_timeout("fc_valid");
        else begin
            check("fc_latency", 64'(cyc - accept_cyc),  64'(LAT_SMALL));
            check("fc_avg",     64'(sbus.avg_pixel),    64'(24'h080808));
            check("fc_count",   64'(sbus.pixel_count),  64'(7));
            check("fc_ovf",     64'(sbus.overflow),     64'(1));
        end
        // avg_ready is held high: handshake now, then the held 8th beat opens a frame.
        send_small(24'h080808, 1'b1);
        w = 0;
        while (!sbus.avg_valid && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (!sbus.avg_valid) fail_timeout("fc8_valid");
        else begin
            check("fc8_latency", 64'(cyc - accept_cyc), 64'(LAT_SMALL));
            check("fc8_avg",     64'(sbus.avg_pixel),   64'(24'h080808));
            check("fc8_count",   64'(sbus.pixel_count), 64'(1));
            check("fc8_ovf",     64'(sbus.overflow),    64'(0));
        end
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
